wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback end of the register-file write port. Accepts retiring instructions from the memory stage and waits for load data when required.
- Formats the result: load extraction, link address or ALU result.
- Drives the regFile write triple (write enable, address, data) consumed by the decode stage.
- Provides upstream back-pressure while a load response is outstanding.

Parameters:
- DATA_W, 32, datapath width (only 32 supported).
- ADDR_W, 5, register address width.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_valid  input  1  instruction presented by memory stage.
- o_ready  output  1  stage can accept this cycle.
- i_c_regWrite  input  1  instruction writes a register.
- i_c_memToReg  input  1  instruction is a load.
- i_c_link  input  1  result is the return address (jal/jalr).
- i_ldType  input  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; others are treated as lw.
- i_wrAddr  input  5  destination register (already regDst-muxed).
- i_aluResult  input  32  ALU result / load effective address.
- i_pcPlus4  input  32  PC+4 of the instruction.
- i_mem_rdata  input  32  load word from data memory.
- i_mem_rvalid  input  1  i_mem_rdata valid this cycle.
- o_c_regWrite  output  1  regFile write enable.
- o_wrAddr  output  5  regFile write address.
- o_wrDataToReg  output  32  regFile write data.
- o_busy  output  1  high in WAIT_LD.

Behaviour:
- Reset: when i_rst_n=0 at a rising edge, state returns to IDLE. o_c_regWrite=0, o_wrAddr=0, o_wrDataToReg=0 and all captured fields clear. Reset applies in every state; an in-flight load is discarded and its later rvalid is ignored.
- All outputs are registered except o_ready and o_busy, which decode from state.
- Accept occurs when i_valid && o_ready.
- On accept, capture regWrite, wrAddr, ldType and aluResult[1:0].
- Result selection on accept:
  - link: data = i_pcPlus4 + 4, mod 2^32.
  - load: go to WAIT_LD.
  - otherwise: data = i_aluResult.
  - If both link and memToReg are set, link wins.
- State IDLE:
  - o_ready=1; o_c_regWrite=0.
  - accept of a non-load -> WRITE; accept of a load -> WAIT_LD.
  - i_mem_rvalid is ignored in IDLE.
- State WAIT_LD:
  - o_ready=0; o_busy=1.
  - On i_mem_rvalid, extract the load value and go to WRITE.
  - Otherwise stay; there is no timeout.
- Load extraction, big-endian; byte k = rdata[31-8k -: 8], k = captured aluResult[1:0].
  - lb/lbu: select byte k, then sign-/zero-extend.
  - lh/lhu: select halfword aluResult[1] (0 -> [31:16], 1 -> [15:0]), then sign-/zero-extend. aluResult[0] is ignored.
  - lw: full word regardless of offset.
- State WRITE:
  - o_c_regWrite = captured regWrite && (wrAddr != 0), for exactly this cycle.
  - o_wrAddr and o_wrDataToReg are valid this cycle.
  - o_ready=1, so a new accept in this same cycle is legal (back-to-back).
  - Next state follows the IDLE accept rules, or IDLE if nothing is accepted.
- Latency and throughput:
  - Non-load: write one cycle after accept; one instruction per cycle sustained.
  - Load: write one cycle after the rvalid cycle.
- Writes to $0 never assert o_c_regWrite. o_wrAddr and o_wrDataToReg still update.
- When o_c_regWrite=0, o_wrAddr and o_wrDataToReg hold their last values.

Test Plan:
- Reset mid-load: accept lw, assert i_rst_n=0 in WAIT_LD, then rvalid -> after reset state is IDLE, all outputs 0, o_ready=1, no write issued.
- Back-to-back ALU ops: accept addr 3 / 0x11111111 then addr 4 / 0x22222222 on consecutive cycles -> o_c_regWrite high two consecutive cycles, (3, 0x11111111) then (4, 0x22222222); o_ready stays 1.
- Load stall: accept lb, addr 5, aluResult=0x1001, rvalid 3 cycles later with rdata=0x12F45678.
  - o_ready=0 for 3 cycles.
  - Next cycle after rvalid: write 5 <- 0xFFFFFFF4.
  - Repeat as lbu -> 0x000000F4; lh with offset 2 -> 0x00005678; lhu with rdata 0x8000xxxx, offset 0 -> 0x00008000.
- Link: accept jal with link=1, addr 31, pcPlus4=0xFFFFFFFC -> write 31 <- 0x00000000 (wrap).
- $0 suppression: accept regWrite=1, addr 0, data 0xDEADBEEF -> o_c_regWrite stays 0 in all cycles.
- Stray rvalid: pulse rvalid in IDLE, then accept a lw -> the stray pulse is ignored and the stage waits for the next rvalid.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: collects retiring instructions, waits for load data when
// needed, formats the result and drives the register-file write port.
module wb_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic              i_c_regWrite,
   input  logic              i_c_memToReg,
   input  logic              i_c_link,
   input  logic [2:0]        i_ldType,
   input  logic [ADDR_W-1:0] i_wrAddr,
   input  logic [DATA_W-1:0] i_aluResult,
   input  logic [DATA_W-1:0] i_pcPlus4,
   input  logic [DATA_W-1:0] i_mem_rdata,
   input  logic              i_mem_rvalid,
   output logic              o_c_regWrite,
   output logic [ADDR_W-1:0] o_wrAddr,
   output logic [DATA_W-1:0] o_wrDataToReg,
   output logic              o_busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_LD = 2'd1,
      WRITE   = 2'd2
   } state_t;

   state_t              state;
   logic                cap_regwrite;
   logic [ADDR_W-1:0]   cap_addr;
   logic [2:0]          cap_ldtype;
   logic [1:0]          cap_off;

   logic                accept;
   logic [7:0]          ld_byte;
   logic [15:0]         ld_half;
   logic [DATA_W-1:0]   ld_value;

   assign o_ready = (state != WAIT_LD);
   assign o_busy  = (state == WAIT_LD);
   assign accept  = i_valid && o_ready;

   // Big-endian byte/halfword selection and extension of the returned load word
   always_comb begin
      ld_byte  = '0;
      ld_half  = '0;
      ld_value = i_mem_rdata;
      case (cap_off)
         2'd0:    ld_byte = i_mem_rdata[31:24];
         2'd1:    ld_byte = i_mem_rdata[23:16];
         2'd2:    ld_byte = i_mem_rdata[15:8];
         default: ld_byte = i_mem_rdata[7:0];
      endcase
      ld_half = cap_off[1] ? i_mem_rdata[15:0] : i_mem_rdata[31:16];
      case (cap_ldtype)
         3'b001:  ld_value = {{(DATA_W-16){ld_half[15]}}, ld_half};
         3'b010:  ld_value = {{(DATA_W-16){1'b0}}, ld_half};
         3'b011:  ld_value = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
         3'b100:  ld_value = {{(DATA_W-8){1'b0}}, ld_byte};
         default: ld_value = i_mem_rdata;
      endcase
   end

   // State machine with registered write-port outputs
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state         <= IDLE;
         cap_regwrite  <= 1'b0;
         cap_addr      <= '0;
         cap_ldtype    <= '0;
         cap_off       <= '0;
         o_c_regWrite  <= 1'b0;
         o_wrAddr      <= '0;
         o_wrDataToReg <= '0;
      end else begin
         case (state)
            WAIT_LD: begin
               o_c_regWrite <= 1'b0;
               if (i_mem_rvalid) begin
                  state         <= WRITE;
                  o_c_regWrite  <= cap_regwrite && (cap_addr != '0);
                  o_wrAddr      <= cap_addr;
                  o_wrDataToReg <= ld_value;
               end
            end
            default: begin
               // IDLE and WRITE share the accept rules; WRITE accepts back-to-back
               o_c_regWrite <= 1'b0;
               state        <= IDLE;
               if (accept) begin
                  cap_regwrite <= i_c_regWrite;
                  cap_addr     <= i_wrAddr;
                  cap_ldtype   <= i_ldType;
                  cap_off      <= i_aluResult[1:0];
                  if (i_c_link) begin
                     state         <= WRITE;
                     o_c_regWrite  <= i_c_regWrite && (i_wrAddr != '0);
                     o_wrAddr      <= i_wrAddr;
                     o_wrDataToReg <= i_pcPlus4 + DATA_W'(4);
                  end else if (i_c_memToReg) begin
                     state <= WAIT_LD;
                  end else begin
                     state         <= WRITE;
                     o_c_regWrite  <= i_c_regWrite && (i_wrAddr != '0);
                     o_wrAddr      <= i_wrAddr;
                     o_wrDataToReg <= i_aluResult;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic        ready;
   logic        c_regwrite;
   logic        c_memtoreg;
   logic        c_link;
   logic [2:0]  ldtype;
   logic [4:0]  wraddr;
   logic [31:0] aluresult;
   logic [31:0] pcplus4;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        busy;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Reference model state
   bit          m_pending;      // load accepted, waiting for data
   bit          m_rw;
   logic [4:0]  m_cap_addr;
   logic [2:0]  m_cap_lt;
   logic [1:0]  m_cap_off;
   bit          m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;

   always #5 clk = ~clk;

   wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_valid       (valid),
      .o_ready       (ready),
      .i_c_regWrite  (c_regwrite),
      .i_c_memToReg  (c_memtoreg),
      .i_c_link      (c_link),
      .i_ldType      (ldtype),
      .i_wrAddr      (wraddr),
      .i_aluResult   (aluresult),
      .i_pcPlus4     (pcplus4),
      .i_mem_rdata   (mem_rdata),
      .i_mem_rvalid  (mem_rvalid),
      .o_c_regWrite  (wr_en),
      .o_wrAddr      (wr_addr),
      .o_wrDataToReg (wr_data),
      .o_busy        (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Load value from the big-endian word, computed arithmetically
   function automatic logic [31:0] load_value(input logic [2:0] lt, input logic [1:0] off,
                                              input logic [31:0] word);
      logic [31:0] b, h;
      b = (word >> (8 * (3 - int'(off)))) & 32'hFF;
      h = off[1] ? (word & 32'hFFFF) : (word >> 16);
      case (lt)
         3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
         3'd2:    return h;
         3'd3:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
         3'd4:    return b;
         default: return word;
      endcase
   endfunction

   task automatic model_write(input bit rw, input logic [4:0] a, input logic [31:0] d);
      m_we   = rw && (a != 5'd0);
      m_addr = a;
      m_data = d;
   endtask

   // Advance the model by one cycle using the inputs currently applied
   task automatic model_cycle();
      if (!rst_n) begin
         m_pending = 0; m_rw = 0; m_cap_addr = '0; m_cap_lt = '0; m_cap_off = '0;
         m_we = 0; m_addr = '0; m_data = '0;
      end else if (m_pending) begin
         m_we = 0;
         if (mem_rvalid) begin
            m_pending = 0;
            model_write(m_rw, m_cap_addr, load_value(m_cap_lt, m_cap_off, mem_rdata));
         end
      end else begin
         m_we = 0;
         if (valid) begin
            m_rw = c_regwrite; m_cap_addr = wraddr; m_cap_lt = ldtype; m_cap_off = aluresult[1:0];
            if (c_link)          model_write(c_regwrite, wraddr, pcplus4 + 32'd4);
            else if (c_memtoreg) m_pending = 1;
            else                 model_write(c_regwrite, wraddr, aluresult);
         end
      end
   endtask

   task automatic step();
      model_cycle();
      @(posedge clk);
      #1;
      check("regwrite", {31'd0, wr_en}, {31'd0, m_we});
      check("wraddr",   {27'd0, wr_addr}, {27'd0, m_addr});
      check("wrdata",   wr_data, m_data);
      check("ready",    {31'd0, ready}, {31'd0, !m_pending});
      check("busy",     {31'd0, busy},  {31'd0, m_pending});
   endtask

   task automatic idle_inputs();
      valid = 0; c_regwrite = 0; c_memtoreg = 0; c_link = 0; ldtype = '0;
      wraddr = '0; aluresult = '0; pcplus4 = '0; mem_rdata = '0; mem_rvalid = 0;
   endtask

   task automatic issue(input bit rw, input bit m2r, input bit lnk, input logic [2:0] lt,
                        input logic [4:0] a, input logic [31:0] alu, input logic [31:0] pc);
      valid = 1; c_regwrite = rw; c_memtoreg = m2r; c_link = lnk; ldtype = lt;
      wraddr = a; aluresult = alu; pcplus4 = pc;
      step();
      idle_inputs();
   endtask

   // Load issued, data returned on the third waiting cycle
   task automatic load_case(input string tag, input logic [2:0] lt, input logic [4:0] a,
                            input logic [31:0] alu, input logic [31:0] word,
                            input logic [31:0] exp);
      issue(1, 1, 0, lt, a, alu, 32'h0);
      check({tag, "_ready0"}, {31'd0, ready}, 32'd0);
      step();
      step();
      mem_rvalid = 1; mem_rdata = word;
      step();
      mem_rvalid = 0;
      check({tag, "_en"},   {31'd0, wr_en}, 32'd1);
      check({tag, "_data"}, wr_data, exp);
      step();
   endtask

   initial begin
      idle_inputs();
      rst_n = 0;
      step();
      step();
      check("rst_data", wr_data, 32'd0);
      check("rst_ready", {31'd0, ready}, 32'd1);
      rst_n = 1;
      step();

      // Back-to-back ALU writes
      valid = 1; c_regwrite = 1; wraddr = 5'd3; aluresult = 32'h1111_1111;
      step();
      check("b2b_a0", {27'd0, wr_addr}, 32'd3);
      wraddr = 5'd4; aluresult = 32'h2222_2222;
      step();
      check("b2b_a1", {27'd0, wr_addr}, 32'd4);
      check("b2b_d1", wr_data, 32'h2222_2222);
      idle_inputs();
      step();

      load_case("lb",  3'd3, 5'd5, 32'h0000_1001, 32'h12F4_5678, 32'hFFFF_FFF4);
      load_case("lbu", 3'd4, 5'd5, 32'h0000_1001, 32'h12F4_5678, 32'h0000_00F4);
      load_case("lh",  3'd1, 5'd6, 32'h0000_1002, 32'h12F4_5678, 32'h0000_5678);
      load_case("lhu", 3'd2, 5'd7, 32'h0000_1000, 32'h8000_ABCD, 32'h0000_8000);
      load_case("lw",  3'd0, 5'd8, 32'h0000_1003, 32'hCAFE_F00D, 32'hCAFE_F00D);

      // Link with wraparound; link beats memToReg
      issue(1, 1, 1, 3'd0, 5'd31, 32'h0, 32'hFFFF_FFFC);
      check("link_data", wr_data, 32'h0);
      check("link_en", {31'd0, wr_en}, 32'd1);
      step();

      // Writes to $0 never enable
      issue(1, 0, 0, 3'd0, 5'd0, 32'hDEAD_BEEF, 32'h0);
      check("r0_en", {31'd0, wr_en}, 32'd0);
      check("r0_data", wr_data, 32'hDEAD_BEEF);
      step();

      // Stray rvalid in IDLE is ignored
      mem_rvalid = 1; mem_rdata = 32'h5555_5555;
      step();
      mem_rvalid = 0;
      issue(1, 1, 0, 3'd0, 5'd9, 32'h0, 32'h0);
      step();
      check("stray_busy", {31'd0, busy}, 32'd1);
      mem_rvalid = 1; mem_rdata = 32'h7777_0001;
      step();
      mem_rvalid = 0;
      check("stray_data", wr_data, 32'h7777_0001);
      step();

      // Reset while waiting for load data
      issue(1, 1, 0, 3'd0, 5'd10, 32'h0, 32'h0);
      rst_n = 0;
      step();
      rst_n = 1;
      mem_rvalid = 1; mem_rdata = 32'h1234_4321;
      step();
      mem_rvalid = 0;
      check("rstld_en", {31'd0, wr_en}, 32'd0);
      check("rstld_data", wr_data, 32'd0);
      check("rstld_ready", {31'd0, ready}, 32'd1);
      step();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         rst_n      = ($urandom_range(99) != 0);
         valid      = $urandom_range(1);
         c_regwrite = ($urandom_range(3) != 0);
         c_memtoreg = $urandom_range(1);
         c_link     = ($urandom_range(5) == 0);
         ldtype     = 3'($urandom_range(7));
         wraddr     = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
         aluresult  = $urandom;
         pcplus4    = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : $urandom;
         mem_rdata  = $urandom;
         mem_rvalid = ($urandom_range(2) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
